// File: rtl/key_event_pkg.sv
// Shared types for the key event reader: per-key FSM states, the queued event record,
// and the helper that sizes the key index.
package key_event_pkg;

  // Widest key index the event record can carry (up to 8 keys).
  localparam int KEY_IDX_MAX_W = 3;

  typedef enum logic [1:0] {
    KEY_IDLE,
    KEY_PRESSED,
    KEY_HELD
  } key_state_t;

  typedef struct packed {
    logic [KEY_IDX_MAX_W-1:0] key;
    logic                     long_press;
  } key_evt_t;

  function automatic int key_idx_w(input int num_keys);
    return (num_keys <= 2) ? 1 : $clog2(num_keys);
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Show-ahead synchronous FIFO of key events. The head entry is visible whenever the
// queue is not empty; a push into a full queue is accepted only if a pop frees a slot.
module key_event_fifo
  import key_event_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     slow_clk,
  input  logic     rst,
  input  logic     push_i,
  input  key_evt_t evt_i,
  input  logic     pop_i,
  output key_evt_t evt_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int AW = $clog2(DEPTH);

  key_evt_t      mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop on an empty queue is ignored; a pop frees the slot a same-edge push lands in.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge slow_clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= evt_i;
  end

  assign evt_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/key_event_reader.sv
// Synchronizes debounced keys, classifies each press as SHORT or LONG, and queues one
// event per press for a valid/ready consumer.
module key_event_reader
  import key_event_pkg::*;
#(
  parameter  int NUM_KEYS   = 2,
  parameter  int LONG_TICKS = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int KEY_IDX_W  = key_idx_w(NUM_KEYS),
  localparam int CNT_W      = $clog2(LONG_TICKS + 1)
) (
  input  logic                 slow_clk,
  input  logic                 rst,
  input  logic [NUM_KEYS-1:0]  in_keys,
  input  logic                 in_evt_ready,
  output logic                 out_evt_valid,
  output logic [KEY_IDX_W-1:0] out_evt_key,
  output logic                 out_evt_long,
  output logic [NUM_KEYS-1:0]  out_held,
  output logic                 out_overflow
);

  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;
  logic [NUM_KEYS-1:0] key_s;

  key_state_t          state_q [NUM_KEYS];
  key_state_t          state_d [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_q   [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d   [NUM_KEYS];
  logic [NUM_KEYS-1:0] raise;
  logic [NUM_KEYS-1:0] raise_long;

  logic [NUM_KEYS-1:0] pend_q, pend_d;
  logic [NUM_KEYS-1:0] pend_long_q, pend_long_d;
  logic                ovf_q, ovf_d;

  logic                 sel_vld;
  logic [KEY_IDX_W-1:0] sel_idx;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  key_evt_t             push_evt;
  key_evt_t             head_evt;
  logic                 head_key_unused;

  assign key_s = sync2_q;

  // Per-key press classifier; cnt counts key_s-high cycles seen while PRESSED.
  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      state_d[k]    = state_q[k];
      cnt_d[k]      = cnt_q[k];
      raise[k]      = 1'b0;
      raise_long[k] = 1'b0;
      unique case (state_q[k])
        KEY_IDLE: begin
          if (key_s[k]) begin
            state_d[k] = KEY_PRESSED;
            cnt_d[k]   = CNT_W'(1);
          end
        end
        KEY_PRESSED: begin
          if (!key_s[k]) begin
            state_d[k] = KEY_IDLE;
            raise[k]   = 1'b1;
          end else if (cnt_q[k] == CNT_W'(LONG_TICKS - 1)) begin
            state_d[k]    = KEY_HELD;
            raise[k]      = 1'b1;
            raise_long[k] = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
          end
        end
        KEY_HELD: begin
          if (!key_s[k]) state_d[k] = KEY_IDLE;
        end
        default: state_d[k] = KEY_IDLE;
      endcase
    end
  end

  // Fixed-priority arbiter: lowest-index pending key wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (pend_q[k]) begin
        sel_vld = 1'b1;
        sel_idx = KEY_IDX_W'(k);
      end
    end
  end

  assign pop  = !fifo_empty && in_evt_ready;
  assign push = sel_vld && (!fifo_full || pop);

  always_comb begin
    push_evt            = '0;
    push_evt.key        = KEY_IDX_MAX_W'(sel_idx);
    push_evt.long_press = pend_long_q[sel_idx];
  end

  // A new event on a key whose previous event is still waiting replaces it and is flagged.
  always_comb begin
    pend_d      = pend_q;
    pend_long_d = pend_long_q;
    ovf_d       = ovf_q;
    if (push) pend_d[sel_idx] = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (raise[k]) begin
        if (pend_d[k]) ovf_d = 1'b1;
        pend_d[k]      = 1'b1;
        pend_long_d[k] = raise_long[k];
      end
    end
  end

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      pend_q      <= '0;
      pend_long_q <= '0;
      ovf_q       <= 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        state_q[k] <= KEY_IDLE;
        cnt_q[k]   <= '0;
      end
    end else begin
      sync1_q     <= in_keys;
      sync2_q     <= sync1_q;
      pend_q      <= pend_d;
      pend_long_q <= pend_long_d;
      ovf_q       <= ovf_d;
      for (int k = 0; k < NUM_KEYS; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .slow_clk (slow_clk),
    .rst      (rst),
    .push_i   (push),
    .evt_i    (push_evt),
    .pop_i    (pop),
    .evt_o    (head_evt),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  // Head fields are forced to 0 when empty so stale storage never reaches the outputs.
  assign out_evt_valid   = !fifo_empty;
  assign out_evt_key     = fifo_empty ? '0 : head_evt.key[KEY_IDX_W-1:0];
  assign out_evt_long    = !fifo_empty && head_evt.long_press;
  assign out_held        = sync2_q;
  assign out_overflow    = ovf_q;
  assign head_key_unused = ^(head_evt.key >> KEY_IDX_W);

endmodule

// File: tb/tb_key_event_reader.sv
// Directed bench for key_event_reader with NUM_KEYS=2, LONG_TICKS=8, FIFO_DEPTH=4.
module tb_key_event_reader;

  logic       slow_clk = 1'b0;
  logic       rst;
  logic [1:0] keys;
  logic       ready;
  logic       valid;
  logic [0:0] evt_key;
  logic       evt_long;
  logic [1:0] held;
  logic       ovf;

  int n_vec  = 0;
  int n_miss = 0;

  key_event_reader #(
    .NUM_KEYS   (2),
    .LONG_TICKS (8),
    .FIFO_DEPTH (4)
  ) dut (
    .slow_clk      (slow_clk),
    .rst           (rst),
    .in_keys       (keys),
    .in_evt_ready  (ready),
    .out_evt_valid (valid),
    .out_evt_key   (evt_key),
    .out_evt_long  (evt_long),
    .out_held      (held),
    .out_overflow  (ovf)
  );

  always #5 slow_clk = ~slow_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge slow_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic press(input logic [1:0] k, input int hi, input int lo);
    keys = k;
    ticks(hi);
    keys = 2'b00;
    ticks(lo);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    keys  = 2'b00;
    ready = 1'b0;
    ticks(2);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] all_out();
    return {26'd0, valid, evt_key, evt_long, held, ovf};
  endfunction

  logic       seen;
  logic [0:0] exp_key [5];
  logic       exp_lng [5];

  initial begin
    rst   = 1'b1;
    keys  = 2'b00;
    ready = 1'b0;
    #1;
    chk("reset_outputs", all_out(), 32'd0);
    do_reset();
    chk("reset_released", all_out(), 32'd0);

    // Short press of key0, released before edge N; valid after N+3.
    ready = 1'b1;
    keys  = 2'b01;
    tick();
    chk("t1_held_e0", 32'(held), 32'd0);
    tick();
    chk("t1_held_e1", 32'(held), 32'd1);
    tick();
    keys = 2'b00;
    ticks(3);
    chk("t1_not_yet", 32'(valid), 32'd0);
    tick();
    chk("t1_valid", 32'(valid), 32'd1);
    chk("t1_key", 32'(evt_key), 32'd0);
    chk("t1_long", 32'(evt_long), 32'd0);
    tick();
    chk("t1_popped", 32'(valid), 32'd0);
    seen = 1'b0;
    repeat (10) begin
      tick();
      seen |= valid;
    end
    chk("t1_no_more", 32'(seen), 32'd0);

    // Long press of key1: event while still held, nothing on release.
    keys = 2'b10;
    tick();
    chk("t2_held_e0", 32'(held), 32'd0);
    tick();
    chk("t2_held_e1", 32'(held), 32'd2);
    ticks(8);
    chk("t2_not_yet", 32'(valid), 32'd0);
    tick();
    chk("t2_valid", 32'(valid), 32'd1);
    chk("t2_key", 32'(evt_key), 32'd1);
    chk("t2_long", 32'(evt_long), 32'd1);
    tick();
    chk("t2_popped", 32'(valid), 32'd0);
    ticks(8);
    keys = 2'b00;
    tick();
    chk("t2_held_still", 32'(held), 32'd2);
    tick();
    chk("t2_held_fall", 32'(held), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      tick();
      seen |= valid;
    end
    chk("t2_no_release_evt", 32'(seen), 32'd0);

    // Both keys released on the same edge: drained in index order.
    keys = 2'b11;
    ticks(2);
    keys = 2'b00;
    ticks(3);
    chk("t3_not_yet", 32'(valid), 32'd0);
    tick();
    chk("t3_first", {29'd0, valid, evt_key, evt_long}, 32'b100);
    tick();
    chk("t3_second", {29'd0, valid, evt_key, evt_long}, 32'b110);
    tick();
    chk("t3_empty", 32'(valid), 32'd0);

    // Consumer stalled: 4 queued, 5th pending, 6th (same key) overwrites it.
    do_reset();
    press(2'b01, 2, 4);
    press(2'b10, 2, 4);
    press(2'b01, 2, 4);
    press(2'b10, 2, 4);
    press(2'b01, 2, 4);
    ticks(4);
    chk("t4_head", {29'd0, valid, evt_key, evt_long}, 32'b100);
    chk("t4_no_ovf_yet", 32'(ovf), 32'd0);
    press(2'b01, 2, 4);
    ticks(4);
    chk("t4_ovf", 32'(ovf), 32'd1);
    chk("t4_head_stable", {29'd0, valid, evt_key, evt_long}, 32'b100);
    exp_key = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_lng = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_drain%0d", i), {29'd0, valid, evt_key, evt_long},
          {29'd0, 1'b1, exp_key[i], exp_lng[i]});
      tick();
    end
    chk("t4_drained", 32'(valid), 32'd0);
    chk("t4_ovf_sticky", 32'(ovf), 32'd1);

    // Full queue with a pending LONG: push and pop share an edge, nothing lost.
    do_reset();
    press(2'b01, 2, 4);
    press(2'b10, 2, 4);
    press(2'b01, 2, 4);
    press(2'b10, 2, 4);
    press(2'b10, 10, 4);
    ticks(4);
    exp_key = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_lng = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5_drain%0d", i), {29'd0, valid, evt_key, evt_long},
          {29'd0, 1'b1, exp_key[i], exp_lng[i]});
      tick();
    end
    chk("t5_drained", 32'(valid), 32'd0);
    chk("t5_no_ovf", 32'(ovf), 32'd0);

    // Reset mid-press with events queued discards everything.
    do_reset();
    press(2'b10, 2, 4);
    press(2'b10, 2, 4);
    ticks(4);
    chk("t6_queued", 32'(valid), 32'd1);
    keys = 2'b01;
    ticks(7);
    chk("t6_held_pre", 32'(held), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_zero", all_out(), 32'd0);
    ticks(2);
    rst   = 1'b0;
    ready = 1'b1;
    seen  = 1'b0;
    repeat (3) begin
      tick();
      seen |= valid;
    end
    keys = 2'b00;
    repeat (3) begin
      tick();
      seen |= valid;
    end
    chk("t6_discarded", 32'(seen), 32'd0);
    tick();
    chk("t6_fresh", {29'd0, valid, evt_key, evt_long}, 32'b100);
    tick();
    chk("t6_end", 32'(valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
